// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// Response owner encoding and default port widths.
package mem_arb_pkg;

  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Bits needed to hold 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating counter of data grants taken while fetch waits.
// Clear wins over increment; at_max flags the saturation value.
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = ARB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = cnt_width(MAX);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d  = cnt_q;
    at_max = (cnt_q == MAX_V);
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one sync-read memory port between fetch and data.
// Data wins by default; a starvation guard forces fetch through.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch
);

  logic   at_max;
  logic   cnt_inc;
  logic   cnt_clr;
  logic   d_req;
  logic   d_rd_only;
  owner_e owner_q;
  owner_e owner_d;
  logic   err_q;
  logic   err_d;

  // Grant: data first, unless fetch waited too long.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    d_req     = d_read | d_write;
    d_rd_only = d_read & ~d_write;
    if (!rst) begin
      if (if_req && at_max) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Memory port; idle cycles still present if_addr.
  always_comb begin
    mem_en      = if_gnt | d_gnt;
    mem_we      = '0;
    mem_addr    = if_addr;
    mem_wdata   = d_wdata;
    stall_fetch = if_req & ~if_gnt;
    if (d_gnt) begin
      mem_addr = d_addr;
      if (d_write) begin
        mem_we = d_be;
      end
    end
  end

  assign cnt_inc = d_gnt & if_req;
  assign cnt_clr = if_gnt | ~if_req;

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (at_max)
  );

  // Who owns next cycle's read data; sticky illegal flag.
  always_comb begin
    err_d = err_q | (d_read & d_write);
    unique case (1'b1)
      if_gnt:             owner_d = OWN_IF;
      (d_gnt & d_rd_only): owner_d = OWN_D;
      default:            owner_d = OWN_NONE;
    endcase
  end

  // Owner and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Route returned data; reset drops any in-flight response.
  always_comb begin
    if_rvalid = ~rst & (owner_q == OWN_IF);
    d_rvalid  = ~rst & (owner_q == OWN_D);
    d_err     = ~rst & err_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter.
// Directed scenarios plus randomized traffic against a model.
module tb_unified_mem_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_fetch;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall_fetch (stall_fetch)
  );

  // Environment memory: word at addr = addr + 0x100 after reset.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 4 + 256);
    end else if (mem_en) begin
      if (mem_we == 4'h0) begin
        mem_rdata <= mem[mem_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b])
            mem[mem_addr[9:2]][8*b+:8] <= mem_wdata[8*b+:8];
      end
    end
  end

  // Reference model state (transaction level).
  int          m_starve = 0;
  int          m_owner = 0;
  logic [31:0] m_exp = '0;
  logic        m_err = 1'b0;
  logic [31:0] sh [0:255];
  logic        e_if, e_d, e_en, e_stall;
  logic [3:0]  e_we;
  logic [31:0] e_addr;

  // Expected issue decision from current inputs.
  task automatic predict();
    e_if = 1'b0;
    e_d  = 1'b0;
    if (!rst) begin
      if (if_req && m_starve == SM) e_if = 1'b1;
      else if (d_read || d_write)   e_d = 1'b1;
      else                          e_if = if_req;
    end
    e_en    = e_if | e_d;
    e_we    = (e_d && d_write) ? d_be : 4'h0;
    e_stall = if_req && !e_if;
    e_addr  = e_d ? d_addr : if_addr;
  endtask

  // Advance one clock, updating the model with this cycle.
  task automatic adv();
    predict();
    if (rst) begin
      m_starve = 0;
      m_owner  = 0;
      m_err    = 1'b0;
      for (int i = 0; i < 256; i++) sh[i] = 32'(i * 4 + 256);
    end else begin
      if (e_if) begin
        m_owner = 1;
        m_exp   = sh[if_addr[9:2]];
      end else if (e_d && d_read && !d_write) begin
        m_owner = 2;
        m_exp   = sh[d_addr[9:2]];
      end else begin
        m_owner = 0;
      end
      if (e_d && d_write)
        for (int b = 0; b < 4; b++)
          if (d_be[b]) sh[d_addr[9:2]][8*b+:8] = d_wdata[8*b+:8];
      if (!if_req || e_if) m_starve = 0;
      else if (e_d && m_starve < SM) m_starve++;
      if (d_read && d_write) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] wd,
                       input logic [3:0] be);
    if_req  = ir;
    if_addr = ia;
    d_read  = dr;
    d_write = dw;
    d_addr  = da;
    d_wdata = wd;
    d_be    = be;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 32'h44, 1, 0, 32'h40, 0, 4'h0);
    @(negedge clk);
    total++;
    if ({if_gnt, d_gnt, mem_en} !== 3'b000) begin
      bad++;
      $display("FAIL rst_gnt got=%b%b%b exp=000", if_gnt, d_gnt, mem_en);
    end
    total++;
    if (mem_we !== 4'h0) begin
      bad++;
      $display("FAIL rst_we got=%h exp=0", mem_we);
    end
    total++;
    if (stall_fetch !== 1'b1) begin
      bad++;
      $display("FAIL rst_stall got=%b exp=1", stall_fetch);
    end
    total++;
    if ({if_rvalid, d_rvalid, d_err} !== 3'b000) begin
      bad++;
      $display("FAIL rst_rv got=%b%b%b exp=000", if_rvalid, d_rvalid, d_err);
    end
    adv();
    rst = 1'b0;
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1, 32'(i * 4), 0, 0, 0, 0, 4'h0);
      else       drive(0, 0, 0, 0, 0, 0, 4'h0);
      @(negedge clk);
      if (i < 5) begin
        total++;
        if (if_gnt !== 1'b1 || stall_fetch !== 1'b0) begin
          bad++;
          $display("FAIL fs_gnt c%0d gnt=%b stall=%b exp=1/0",
                   i, if_gnt, stall_fetch);
        end
      end
      if (i > 0) begin
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'(256 + (i - 1) * 4)) begin
          bad++;
          $display("FAIL fs_data c%0d rv=%b got=%h exp=%h",
                   i, if_rvalid, if_rdata, 32'(256 + (i - 1) * 4));
        end
      end
      adv();
    end
  endtask

  task automatic test_load_collide();
    drive(1, 32'h14, 1, 0, 32'h40, 0, 4'h0);
    @(negedge clk);
    total++;
    if ({d_gnt, if_gnt, stall_fetch} !== 3'b101 || mem_addr !== 32'h40) begin
      bad++;
      $display("FAIL lc_issue got=%b%b%b addr=%h exp=101 40",
               d_gnt, if_gnt, stall_fetch, mem_addr);
    end
    adv();
    drive(1, 32'h14, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h140) begin
      bad++;
      $display("FAIL lc_load rv=%b got=%h exp=140", d_rvalid, d_rdata);
    end
    total++;
    if (if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL lc_fetch gnt=%b rv=%b exp=1/0", if_gnt, if_rvalid);
    end
    adv();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h114 || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL lc_fdata rv=%b got=%h drv=%b exp=1 114 0",
               if_rvalid, if_rdata, d_rvalid);
    end
    adv();
  endtask

  task automatic test_store_be();
    drive(0, 0, 0, 1, 32'h20, 32'h11223344, 4'hF);
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1 || mem_we !== 4'hF) begin
      bad++;
      $display("FAIL st_pre gnt=%b we=%h exp=1 f", d_gnt, mem_we);
    end
    adv();
    drive(0, 0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0011);
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1 || mem_we !== 4'b0011) begin
      bad++;
      $display("FAIL st_be gnt=%b we=%b exp=1 0011", d_gnt, mem_we);
    end
    adv();
    drive(0, 0, 1, 0, 32'h20, 0, 4'h0);
    @(negedge clk);
    total++;
    if (d_rvalid !== 1'b0 || mem_we !== 4'h0 || d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL st_rd rv=%b we=%h gnt=%b exp=0 0 1",
               d_rvalid, mem_we, d_gnt);
    end
    adv();
    drive(1, 0, 0, 1, 32'h24, 32'hDEADBEEF, 4'h0);
    @(negedge clk);
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122CCDD) begin
      bad++;
      $display("FAIL st_data rv=%b got=%h exp=1122ccdd", d_rvalid, d_rdata);
    end
    total++;
    if ({d_gnt, if_gnt, mem_en} !== 3'b101 || mem_we !== 4'h0) begin
      bad++;
      $display("FAIL st_be0 got=%b%b%b we=%h exp=101 0",
               d_gnt, if_gnt, mem_en, mem_we);
    end
    adv();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    adv();
  endtask

  task automatic test_starve();
    logic [5:0] pat;
    pat = 6'b10_1111;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h30, 1, 0, 32'(32'h80 + i * 4), 0, 4'h0);
      @(negedge clk);
      total++;
      if (d_gnt !== pat[i] || if_gnt !== ~pat[i]) begin
        bad++;
        $display("FAIL starve c%0d d=%b if=%b exp_d=%b",
                 i, d_gnt, if_gnt, pat[i]);
      end
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    adv();
  endtask

  task automatic test_reset_mid_read();
    drive(1, 32'h8, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    total++;
    if (if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rm_issue got=%b exp=1", if_gnt);
    end
    adv();
    rst = 1'b1;
    drive(1, 32'hC, 1, 0, 32'h40, 0, 4'h0);
    @(negedge clk);
    total++;
    if ({if_rvalid, mem_en, if_gnt, d_gnt} !== 4'b0000) begin
      bad++;
      $display("FAIL rm_rst got=%b%b%b%b exp=0000",
               if_rvalid, mem_en, if_gnt, d_gnt);
    end
    adv();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    total++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rm_after rv=%b%b exp=00", if_rvalid, d_rvalid);
    end
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h10, 1, 0, 32'h40, 0, 4'h0);
      adv();
    end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h10, 1, 0, 32'h40, 0, 4'h0);
      @(negedge clk);
      total++;
      if (d_gnt !== (i < 4) || if_gnt !== (i == 4)) begin
        bad++;
        $display("FAIL rm_cnt c%0d d=%b if=%b exp_d=%b",
                 i, d_gnt, if_gnt, (i < 4));
      end
      adv();
    end
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    adv();
  endtask

  task automatic test_illegal();
    drive(0, 0, 1, 1, 32'h50, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1 || mem_we !== 4'hF || d_err !== 1'b0) begin
      bad++;
      $display("FAIL il_issue gnt=%b we=%h err=%b exp=1 f 0",
               d_gnt, mem_we, d_err);
    end
    adv();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    total++;
    if (d_err !== 1'b1 || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL il_err err=%b rv=%b exp=1 0", d_err, d_rvalid);
    end
    adv();
    drive(0, 0, 1, 0, 32'h50, 0, 4'h0);
    adv();
    drive(0, 0, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFEF00D || d_err !== 1'b1) begin
      bad++;
      $display("FAIL il_data rv=%b got=%h err=%b exp=1 cafef00d 1",
               d_rvalid, d_rdata, d_err);
    end
    adv();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (d_err !== 1'b0) begin
      bad++;
      $display("FAIL il_rst err=%b exp=0", d_err);
    end
    adv();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (d_err !== 1'b0) begin
      bad++;
      $display("FAIL il_clear err=%b exp=0", d_err);
    end
    adv();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 9);
      drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 255) * 4),
            (r < 3) || (r == 6), (r >= 3 && r <= 6),
            32'($urandom_range(0, 255) * 4), $urandom,
            4'($urandom_range(0, 15)));
      @(negedge clk);
      predict();
      total++;
      if ({if_gnt, d_gnt, mem_en, stall_fetch} !==
          {e_if, e_d, e_en, e_stall}) begin
        bad++;
        $display("FAIL rnd_gnt c%0d got=%b%b%b%b exp=%b%b%b%b", i,
                 if_gnt, d_gnt, mem_en, stall_fetch,
                 e_if, e_d, e_en, e_stall);
      end
      total++;
      if (mem_we !== e_we || (e_en && mem_addr !== e_addr)) begin
        bad++;
        $display("FAIL rnd_mem c%0d we=%h addr=%h exp=%h %h",
                 i, mem_we, mem_addr, e_we, e_addr);
      end
      total++;
      if (if_rvalid !== (m_owner == 1 && !rst) ||
          d_rvalid !== (m_owner == 2 && !rst) ||
          d_err !== (m_err && !rst)) begin
        bad++;
        $display("FAIL rnd_rv c%0d got=%b%b%b own=%0d err=%b",
                 i, if_rvalid, d_rvalid, d_err, m_owner, m_err);
      end
      if (m_owner == 1 && !rst) begin
        total++;
        if (if_rdata !== m_exp) begin
          bad++;
          $display("FAIL rnd_ifd c%0d got=%h exp=%h", i, if_rdata, m_exp);
        end
      end
      if (m_owner == 2 && !rst) begin
        total++;
        if (d_rdata !== m_exp) begin
          bad++;
          $display("FAIL rnd_dd c%0d got=%h exp=%h", i, d_rdata, m_exp);
        end
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_load_collide();
    test_store_be();
    test_starve();
    test_reset_mid_read();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, synchronous-read memory between instruction fetch (IF) and the data access stage (load/store, driven by the MemRead/MemWrite control signals).
- Issues at most one memory access per cycle and routes read data back to whichever requester issued the read.
- Data accesses have priority over fetch. A starvation guard makes sure fetch still progresses.
- Drives `stall_fetch`, which holds the PC and IF stage while fetch is not granted.

Parameters:
- ADDR_W, 32, address width of requesters and memory
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_MAX, 4, consecutive data grants allowed while `if_req` is pending before fetch is forced; must be ≥ 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request issued to memory this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_read  in  1  data load request (MemRead)
- d_write  in  1  data store request (MemWrite)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request issued this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- d_err  out  1  sticky: `d_read` and `d_write` were asserted together
- mem_en  out  1  memory access enable
- mem_we  out  DATA_W/8  per-byte write enable; all zero for reads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read
- stall_fetch  out  1  `if_req && !if_gnt`

Behaviour:
- Clock and reset
  - Single clock. Reset is synchronous and active-high.
- Memory timing
  - A read issued in cycle N returns `mem_rdata` in cycle N+1.
  - A write completes in the cycle it is issued.
- Issue logic (combinational, same cycle)
  - Grant at most one requester per cycle.
  - The granted requester's address, data and byte enables drive `mem_*`.
  - `mem_en = if_gnt | d_gnt`.
- Priority
  - Default: data (`d_read | d_write`) wins over `if_req`.
  - Exception: if `starve_cnt == STARVE_MAX` and `if_req == 1`, fetch wins for that cycle.
- Starvation counter `starve_cnt` (0..STARVE_MAX, saturating)
  - Increments when `d_gnt && if_req`.
  - Clears on `if_gnt` or when `if_req == 0`.
- Illegal data request
  - If `d_read && d_write`: treat as a write using `d_be`, and set `d_err` (stays set until reset).
- Writes
  - `mem_we = d_be` on a data write grant; `mem_we = 0` otherwise.
  - `d_be == 0` with `d_write` still consumes a grant.
- Response owner register, states NONE / IF / D
  - On a clock edge it loads IF if `if_gnt` this cycle, D if `d_gnt` was a read, else NONE.
  - `if_rvalid = (owner == IF)`; `d_rvalid = (owner == D)`.
  - `if_rdata` and `d_rdata` are both wired to `mem_rdata`, qualified by the matching `rvalid`.
- Back-to-back operation
  - A new access may issue in the same cycle a response is returned.
  - Reads can be granted every cycle with no bubble.
- Reset values (required in the cycle `rst` is high)
  - owner = NONE, `starve_cnt` = 0, `d_err` = 0.
  - All grants, `rvalid`s and `mem_en` are forced to 0; `mem_we` is forced to 0.
  - `stall_fetch` equals `if_req`.
- Reset during an outstanding read
  - The response is discarded: no `rvalid` in the following cycle.
- No-request cycle
  - `mem_en = 0`; `mem_addr` and `mem_wdata` are don't-care but must not be X in simulation. Drive `if_addr`.

Decomposition:
- Shared package `mem_arb_pkg`:
  - owner encoding `OWN_NONE = 2'd0`, `OWN_IF = 2'd1`, `OWN_D = 2'd2`
  - default widths
- Sub-module `starve_counter`: saturating counter with inc / clr / `at_max`. This is the only natural split; the rest stays flat in one module.

Test Plan:
- Fetch only, stream of reads
  - Stimulus: `if_req = 1` held for 5 cycles, addresses 0x0, 0x4, 0x8, 0xC, 0x10; memory preloaded with word = address + 0x100.
  - Required: `if_gnt` every cycle; `if_rvalid` from cycle 2 onward; `if_rdata` = 0x100, 0x104, … in order; `stall_fetch` = 0.
- Load collides with fetch
  - Stimulus: `if_req = 1` and `d_read = 1` at `d_addr = 0x40` in the same cycle.
  - Required: `d_gnt = 1`, `if_gnt = 0`, `stall_fetch = 1`; next cycle `d_rvalid = 1` with `d_rdata = mem[0x40]`, and the fetch is granted.
- Store with byte enables
  - Stimulus: `d_write = 1`, `d_addr = 0x20`, `d_wdata = 0xAABBCCDD`, `d_be = 4'b0011`, over prior word 0x11223344.
  - Required: `mem_we = 4'b0011` in the same cycle; a later read of 0x20 returns 0x1122CCDD; no `d_rvalid` for the store.
- Starvation guard
  - Stimulus: `if_req = 1` plus 6 consecutive data reads, with `STARVE_MAX = 4`.
  - Required: data granted for 4 cycles, fetch granted on cycle 5, data resumes on cycle 6.
- Reset mid-read
  - Stimulus: issue a fetch read, then assert `rst` on the next cycle.
  - Required: `if_rvalid = 0` in the reset cycle and after; `starve_cnt = 0`; `mem_en = 0` while `rst` is high.
- Illegal request
  - Stimulus: `d_read = d_write = 1`, `d_be = 4'hF`.
  - Required: the write is performed; `d_err` = 1 from the next cycle and stays set until `rst`.
